button_press_generator: RTL and testbench

BUTTON_PRESS_GENERATOR -- requirements
Module: button_press_generator

---
 rtl/button_press_pkg.sv | 19 +
 rtl/phase_timer.sv | 33 +++
 rtl/button_press_generator.sv | 191 +++++++++++++++++++
 tb/tb_button_press_generator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/button_press_pkg.sv
// Shared definitions for the button press generator.
//   state_t      : FSM state type (IDLE, HIGH, LOW, FINISH)
//   CNT_W_DEF    : default width of the press-count and phase-length fields
//   NUM_BTN_DEF  : default number of button lines
//   MIN_PHASE    : a programmed phase length of 0 is treated as this value
package button_press_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int NUM_BTN_DEF = 3;
    localparam int MIN_PHASE   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   load_i     : load load_val_i into the counter on the next edge
//   load_val_i : phase length in clocks, always >= 1
//   expired_o  : current cycle is the last cycle of the loaded phase
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // A phase loaded with N spends N cycles in its state; the N-th cycle
    // is the one where the counter holds 1.
    assign expired_o = (cnt_q <= W'(1));

endmodule

// File: rtl/button_press_generator.sv
// Emits a train of button presses on one of NUM_BTN active-high lines.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   start        : command strobe, sampled only in IDLE
//   abort        : synchronous cancel of a running train (wins over start)
//   sel          : target button index, valid 0..NUM_BTN-1
//   count        : number of presses to emit
//   high_cycles  : press phase length (0 treated as 1)
//   low_cycles   : release phase length (0 treated as 1)
//   buttons      : registered button lines, one-hot or zero
//   busy         : train in progress
//   done         : one-cycle pulse on normal completion
//   err          : one-cycle pulse on a rejected command (bad sel)
//   presses_sent : presses completed in the current or last train
//   dbg_state    : current FSM state
// Handshake: start is a single-cycle strobe with no ready; it is accepted
// only when the FSM is IDLE and abort is low, otherwise it is dropped.
module button_press_generator
    import button_press_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_BTN = NUM_BTN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         sel,
    input  logic [CNT_W-1:0]   count,
    input  logic [CNT_W-1:0]   high_cycles,
    input  logic [CNT_W-1:0]   low_cycles,
    output logic [NUM_BTN-1:0] buttons,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   presses_sent,
    output state_t             dbg_state
);

    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(MIN_PHASE) : v;
    endfunction

    function automatic logic [NUM_BTN-1:0] onehot(input logic [1:0] idx);
        logic [NUM_BTN-1:0] o;
        for (int i = 0; i < NUM_BTN; i++) begin
            o[i] = (int'(idx) == i);
        end
        return o;
    endfunction

    state_t             state_q;
    logic [1:0]         sel_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   hi_len_q;
    logic [CNT_W-1:0]   lo_len_q;
    logic [CNT_W-1:0]   presses_q;
    logic [NUM_BTN-1:0] buttons_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               sel_ok;
    logic               more_presses;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expired;

    assign sel_ok       = (int'(sel) < NUM_BTN);
    // presses_q was already bumped on entry to LOW.
    assign more_presses = (presses_q < count_q);

    // The timer is reloaded on every edge that enters HIGH or LOW.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = hi_len_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort && sel_ok && (count != '0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = clamp_len(high_cycles);
                end
            end
            ST_HIGH: begin
                if (!abort && tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = lo_len_q;
                end
            end
            ST_LOW: begin
                if (!abort && tmr_expired && more_presses) begin
                    tmr_load = 1'b1;
                    tmr_val  = hi_len_q;
                end
            end
            default: ;
        endcase
    end

    phase_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            count_q   <= '0;
            hi_len_q  <= CNT_W'(MIN_PHASE);
            lo_len_q  <= CNT_W'(MIN_PHASE);
            presses_q <= '0;
            buttons_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (!sel_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            sel_q     <= sel;
                            count_q   <= count;
                            hi_len_q  <= clamp_len(high_cycles);
                            lo_len_q  <= clamp_len(low_cycles);
                            presses_q <= '0;
                            if (count == '0) begin
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= ST_HIGH;
                                buttons_q <= onehot(sel);
                                busy_q    <= 1'b1;
                            end
                        end
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        buttons_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (tmr_expired) begin
                        state_q   <= ST_LOW;
                        buttons_q <= '0;
                        // Saturate so a full-scale count never wraps.
                        if (presses_q != count_q) begin
                            presses_q <= presses_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmr_expired) begin
                        if (more_presses) begin
                            state_q   <= ST_HIGH;
                            buttons_q <= onehot(sel_q);
                        end else begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign buttons      = buttons_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign presses_sent = presses_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_button_press_generator.sv
module tb_button_press_generator;
    import button_press_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] sel;
    logic [3:0] count;
    logic [3:0] high_cycles;
    logic [3:0] low_cycles;
    logic [2:0] buttons;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] presses_sent;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    button_press_generator #(.CNT_W(4), .NUM_BTN(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .sel          (sel),
        .count        (count),
        .high_cycles  (high_cycles),
        .low_cycles   (low_cycles),
        .buttons      (buttons),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .presses_sent (presses_sent),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] s, input logic [3:0] c,
                         input logic [3:0] h, input logic [3:0] l);
        sel = s; count = c; high_cycles = h; low_cycles = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [2:0]  exp_q[$];
    logic        exp_done[8];
    logic        exp_busy[8];
    int          busy_cnt;
    int          done_cnt;
    logic [11:0] seq;
    logic [1:0]  other;
    logic        got_done;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        sel = '0; count = '0; high_cycles = '0; low_cycles = '0;

        // reset state
        repeat (2) tick();
        check("rst_buttons", 32'(buttons), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_presses", 32'(presses_sent), 0);
        rst = 1'b1;
        tick();

        // sel=2 count=3 high=1 low=1: 1,0,1,0,1,0 then done
        exp_q = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        exp_done = '{0, 0, 0, 0, 0, 0, 1, 0};
        exp_busy = '{1, 1, 1, 1, 1, 1, 0, 0};
        issue(2'd2, 4'd3, 4'd1, 4'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check($sformatf("t1_buttons_e%0d", k), 32'(buttons), 32'(exp_q.pop_front()));
            check($sformatf("t1_done_e%0d", k), 32'(done), 32'(exp_done[k]));
            check($sformatf("t1_busy_e%0d", k), 32'(busy), 32'(exp_busy[k]));
            if (k == 6) check("t1_presses", 32'(presses_sent), 3);
        end

        // sel=0 count=2 high=3 low=0: 3 high / 1 low twice, busy 8 cycles
        busy_cnt = 0; done_cnt = 0; seq = '0; other = '0;
        issue(2'd0, 4'd2, 4'd3, 4'd0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            seq   = {seq[10:0], buttons[0]};
            other = other | buttons[2:1];
        end
        check("t2_pattern", 32'(seq), 32'h0EE0);
        check("t2_busy_cycles", busy_cnt, 8);
        check("t2_done_count", done_cnt, 1);
        check("t2_other_lines", 32'(other), 0);
        check("t2_presses", 32'(presses_sent), 2);

        // count=0: immediate done, no button activity
        issue(2'd1, 4'd0, 4'd2, 4'd2);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_buttons", 32'(buttons), 0);
        check("t3_presses", 32'(presses_sent), 0);
        tick();
        check("t3_done_clear", 32'(done), 0);
        check("t3_idle", 32'(dbg_state), 32'(ST_IDLE));

        // sel=3: rejected with err pulse
        issue(2'd3, 4'd2, 4'd1, 4'd1);
        check("t3_err", 32'(err), 1);
        check("t3_err_busy", 32'(busy), 0);
        check("t3_err_buttons", 32'(buttons), 0);
        check("t3_err_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("t3_err_clear", 32'(err), 0);

        // sel=1 count=5 high=2 low=1, abort during 3rd HIGH
        issue(2'd1, 4'd5, 4'd2, 4'd1);
        repeat (6) tick();
        check("t4_third_high", 32'(buttons), 32'b010);
        check("t4_presses_pre", 32'(presses_sent), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_buttons", 32'(buttons), 0);
        check("t4_abort_busy", 32'(busy), 0);
        check("t4_abort_presses", 32'(presses_sent), 2);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            done_cnt += int'(done);
        end
        check("t4_no_done", done_cnt, 0);

        // abort together with start in IDLE drops the command
        abort = 1'b1;
        issue(2'd0, 4'd1, 4'd1, 4'd1);
        abort = 1'b0;
        check("t4_drop_busy", 32'(busy), 0);
        check("t4_drop_buttons", 32'(buttons), 0);
        check("t4_drop_presses", 32'(presses_sent), 2);

        // fresh start runs normally
        issue(2'd1, 4'd1, 4'd1, 4'd1);
        check("t4_new_buttons", 32'(buttons), 32'b010);
        check("t4_new_presses0", 32'(presses_sent), 0);
        tick();
        check("t4_new_low", 32'(buttons), 0);
        check("t4_new_presses1", 32'(presses_sent), 1);
        tick();
        check("t4_new_done", 32'(done), 1);

        // async reset mid-HIGH
        tick();
        issue(2'd0, 4'd4, 4'd1, 4'd1);
        repeat (2) tick();
        check("t5_pre_buttons", 32'(buttons), 32'b001);
        check("t5_pre_presses", 32'(presses_sent), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_buttons", 32'(buttons), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_presses", 32'(presses_sent), 0);
        check("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // count=15 must reach 15 without wrapping
        issue(2'd2, 4'd15, 4'd1, 4'd1);
        got_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("t5_done_seen", 32'(got_done), 1);
        check("t5_presses15", 32'(presses_sent), 15);
        check("t5_buttons_end", 32'(buttons), 0);
        tick();
        check("t5_presses_hold", 32'(presses_sent), 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
